mac_result_buffer: RTL and testbench
====================================

Name: mac_result_buffer

Overview:
- Downstream stage of the sum-of-squares MAC. Captures every 20-bit accumulator result presented with valid_out into a small circular FIFO, so the MAC (which has no backpressure) never stalls.
- Detects accumulator wrap-around modulo 2^WIDTH, tags the affected entry, and drains results to the consumer through a valid/ready handshake.

Parameters:
WIDTH, 20, accumulator/result width (matches MAC f)
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
f_in  in  WIDTH  MAC accumulator value (MAC f)
valid_in  in  1  f_in valid this cycle (MAC valid_out)
out_data  out  WIDTH  head-of-FIFO result
out_wrap  out  1  head entry was the sample at which a wrap was detected
out_valid  out  1  head entry present
out_ready  in  1  consumer accepts head this cycle
count  out  CNT_W  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: a wrap has been detected since reset or last clear
overflow_clr  in  1  synchronous clear of overflow
drop  out  1  one-cycle pulse: valid_in sample discarded because FIFO full
drop_count  out  8  saturating dropped-sample counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, any time, including mid-operation) clears all state: rd/wr pointers = 0; count = 0; empty = 1; full = 0; out_valid = 0; overflow = 0; drop = 0; drop_count = 0; prev_f = 0. out_data and out_wrap are don't-care while out_valid = 0.
- Storage: DEPTH entries of WIDTH+1 bits ({wrap_tag, f}). Pointers wrap from DEPTH-1 to 0.
- Push: valid_in = 1 and (count < DEPTH, or a pop occurs in the same cycle). The entry is written at the rising edge.
  - First-word fall-through: a sample pushed into an empty FIFO at edge N gives out_valid = 1 with that data after edge N.
- Pop: out_valid & out_ready at the edge advances rd_ptr. out_data/out_wrap are read combinationally at rd_ptr.
  - out_valid = !empty. out_ready while empty is ignored.
- Simultaneous push and pop:
  - Full: both happen; count stays DEPTH; no drop.
  - Empty: only the push happens (out_valid was 0); count becomes 1.
  - Otherwise: count is unchanged.
- Drop: valid_in = 1, full = 1 and no pop in the same cycle. The sample is discarded, drop = 1 for that cycle, and the FIFO contents are unchanged.
- Wrap detection: on every valid_in = 1, whether pushed or dropped:
  - wrap = (f_in < prev_f), unsigned compare; then prev_f <= f_in.
  - If wrap: overflow <= 1, and the pushed entry's wrap_tag = 1.
  - Equal values are not a wrap.
- overflow_clr = 1 forces overflow <= 0 in that cycle, unless a wrap is detected in the same cycle, in which case overflow stays 1 (set wins).
- No arithmetic on data; widths are passed through unchanged.

Optional Feature:
- Macro: MAC_RESULT_BUFFER_DROP_CNT_EN.
- Defined: drop_count is an 8-bit counter that increments on each drop pulse and saturates at 255. It is cleared only by reset.
- Not defined: no counter logic is built and drop_count is tied to 0. The port remains present, so the interface is identical in both builds.

Test Plan:
- Basic fill/drain, out_ready = 0: push 441, 1737, 5833, 70858 on consecutive cycles -> count = 4, out_valid = 1, out_data = 441. Then out_ready = 1 for 4 cycles -> out_data 441, 1737, 5833, 70858 in order, then empty = 1, out_valid = 0.
- Full and drop, out_ready = 0, DEPTH = 8: push 9 samples 1..9 -> full = 1 after the 8th; 9th gives drop = 1 for one cycle. drop_count = 1 with macro, 0 without. Drain yields 1..8 only.
- Push+pop at full: FIFO full, valid_in = 1 with f_in = 100 and out_ready = 1 in the same cycle -> no drop, count stays 8, 100 appears last on drain.
- Wrap: push 1048000 then 4000 -> overflow = 1. Second entry drains with out_wrap = 1; first with out_wrap = 0. Later overflow_clr = 1 -> overflow = 0. Push of 4000 again (equal value) -> no wrap.
- Set-wins: overflow_clr = 1 in the same cycle as a wrapping sample (prev 5000, f_in 10) -> overflow remains 1.
- Reset mid-operation: 3 entries held and overflow = 1; assert reset between clock edges -> immediately count = 0, empty = 1, out_valid = 0, overflow = 0, drop_count = 0. After release, push 7 -> out_data = 7, out_wrap = 0, since prev_f was reset to 0.

Source files
------------

// File: rtl/mac_result_buffer.sv
// Circular result FIFO behind the sum-of-squares MAC, with wrap-around tagging and sticky overflow.
// Optional build macro MAC_RESULT_BUFFER_DROP_CNT_EN adds a saturating dropped-sample counter.
module mac_result_buffer #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] f_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_wrap,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             drop,
  output logic [7:0]       drop_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH:0]     mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [WIDTH-1:0]   prev_f_r;
  logic               overflow_r;
  logic               drop_r;

  logic               empty_s;
  logic               full_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic               wrap_s;
  logic [CNT_W-1:0]   count_nxt_s;

  // Handshake decode: a pop at full frees the slot the concurrent push lands in.
  always_comb begin
    empty_s     = (count_r == {CNT_W{1'b0}});
    full_s      = (count_r == CNT_W'(DEPTH));
    pop_s       = !empty_s && out_ready;
    push_s      = valid_in && (!full_s || pop_s);
    drop_s      = valid_in && full_s && !pop_s;
    wrap_s      = valid_in && (f_in < prev_f_r);
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy, wrap-history and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      prev_f_r   <= {WIDTH{1'b0}};
      overflow_r <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      if (valid_in) prev_f_r <= f_in;
      count_r <= count_nxt_s;
      drop_r  <= drop_s;
      // A wrap in the same cycle as a clear keeps the flag set.
      if (wrap_s)            overflow_r <= 1'b1;
      else if (overflow_clr) overflow_r <= 1'b0;
    end
  end

  // Entry storage; contents are only meaningful behind the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {wrap_s, f_in};
  end

`ifdef MAC_RESULT_BUFFER_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating count of discarded samples, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             drop_cnt_r <= 8'd0;
    else if (drop_s && drop_cnt_r != 8'd255) drop_cnt_r <= drop_cnt_r + 8'd1;
  end

  assign drop_count = drop_cnt_r;
`else
  assign drop_count = 8'd0;
`endif

  assign out_data  = mem_r[rd_ptr_r][WIDTH-1:0];
  assign out_wrap  = mem_r[rd_ptr_r][WIDTH];
  assign out_valid = !empty_s;
  assign count     = count_r;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_r;
  assign drop      = drop_r;

endmodule

// File: tb/tb_mac_result_buffer.sv
// Randomized bench for mac_result_buffer against a queue-based reference model.
module tb_mac_result_buffer;

  localparam int WIDTH = 20;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] f_in;
  logic             valid_in;
  logic [WIDTH-1:0] out_data;
  logic             out_wrap;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             overflow_clr;
  logic             drop;
  logic [7:0]       drop_count;

  mac_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .f_in(f_in), .valid_in(valid_in),
    .out_data(out_data), .out_wrap(out_wrap), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .overflow_clr(overflow_clr), .drop(drop),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH:0]   q[$];
  logic [WIDTH-1:0] m_prev;
  logic             m_ovf;
  logic             m_drop;
  int               m_dc;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_dc();
`ifdef MAC_RESULT_BUFFER_DROP_CNT_EN
    return m_dc;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_prev = '0;
    m_ovf  = 1'b0;
    m_drop = 1'b0;
    m_dc   = 0;
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(q[0][WIDTH-1:0]));
      check("out_wrap", 32'(out_wrap), 32'(q[0][WIDTH]));
    end
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop", 32'(drop), 32'(m_drop));
    check("drop_count", 32'(drop_count), 32'(exp_dc()));
  endtask

  // One clock: apply inputs, advance the model by the specified rules, then compare.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] f, input logic rdy, input logic clr);
    logic was_full, do_pop, do_wrap;
    valid_in = v; f_in = f; out_ready = rdy; overflow_clr = clr;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    do_pop   = (q.size() != 0) && rdy;
    do_wrap  = v && (f < m_prev);
    if (v) m_prev = f;
    if (do_pop) void'(q.pop_front());
    if (v && (!was_full || do_pop)) q.push_back({do_wrap, f});
    m_drop = v && was_full && !do_pop;
    if (m_drop && m_dc < 255) m_dc++;
    if (do_wrap) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    check_all();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    valid_in = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_count", 32'(count), 32'd0);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; f_in = '0; out_ready = 1'b0; overflow_clr = 1'b0;
    model_reset();
    #12;
    check_all();
    reset = 1'b0;
    #1;

    // Basic fill then drain
    cycle(1'b1, 20'd441, 1'b0, 1'b0);
    cycle(1'b1, 20'd1737, 1'b0, 1'b0);
    cycle(1'b1, 20'd5833, 1'b0, 1'b0);
    cycle(1'b1, 20'd70858, 1'b0, 1'b0);
    check("fill_head", 32'(out_data), 32'd441);
    drain(4);
    check("drained_empty", 32'(empty), 32'd1);

    // Fill to full, one drop, push+pop at full, drain
    for (int i = 1; i <= 9; i++) cycle(1'b1, 20'(i), 1'b0, 1'b0);
    check("drop_pulse", 32'(drop), 32'd1);
    cycle(1'b1, 20'd100, 1'b1, 1'b0);
    check("full_pushpop_cnt", 32'(count), 32'(DEPTH));
    drain(DEPTH + 1);

    // Wrap tagging, clear, equal value is not a wrap
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 20'd1048000, 1'b0, 1'b0);
    cycle(1'b1, 20'd4000, 1'b0, 1'b0);
    check("wrap_ovf", 32'(overflow), 32'd1);
    drain(2);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 20'd4000, 1'b0, 1'b0);
    check("equal_nowrap", 32'(out_wrap), 32'd0);
    drain(1);

    // Set wins over clear
    cycle(1'b1, 20'd5000, 1'b0, 1'b1);
    cycle(1'b1, 20'd10, 1'b0, 1'b1);
    check("set_wins", 32'(overflow), 32'd1);
    drain(2);

    // Reset mid-operation
    cycle(1'b1, 20'd900, 1'b0, 1'b0);
    cycle(1'b1, 20'd50, 1'b0, 1'b0);
    cycle(1'b1, 20'd60, 1'b0, 1'b0);
    async_reset();
    cycle(1'b1, 20'd7, 1'b0, 1'b0);
    check("post_rst_data", 32'(out_data), 32'd7);
    check("post_rst_wrap", 32'(out_wrap), 32'd0);

    // Randomized traffic with varying consumer pressure
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      logic [WIDTH-1:0] f;
      rdy_pct = ((i / 200) % 3 == 0) ? 15 : (((i / 200) % 3 == 1) ? 85 : 50);
      f = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, (1 << WIDTH) - 1))
                                       : m_prev + WIDTH'($urandom_range(0, 40));
      cycle($urandom_range(0, 99) < 70, f, $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 7) == 0);
      if (i == 1500) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
